// File: rtl/hist_pkg.sv
// Shared definitions for the histogram packet path: packet/dump word layouts,
// default bin geometry, sink FSM states and the bin base-address helper.
package hist_pkg;

  localparam int          ADDR_W         = 12;
  localparam int          DATA_W         = 8;
  localparam logic [11:0] DEF_BASE_ADDR  = 12'h020;
  localparam logic [11:0] DEF_BIN_STRIDE = 12'h020;

  // Incoming packet: {rsvd[31:28], cnt[27:20], storage_addr[19:8], value[7:0]}
  typedef struct packed {
    logic [3:0]  rsvd;
    logic [7:0]  cnt;
    logic [11:0] sa;
    logic [7:0]  val;
  } pkt_t;

  // Dump word: {5'b0, bin[2:0], 4'b0, addr[11:0], value[7:0]}
  typedef struct packed {
    logic [4:0]  pad0;
    logic [2:0]  bin;
    logic [3:0]  pad1;
    logic [11:0] addr;
    logic [7:0]  val;
  } dump_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DUMP_RD,
    ST_DUMP_OUT,
    ST_CLEAR
  } state_e;

  function automatic logic [11:0] get_storage_address(input logic [11:0] bin,
                                                      input logic [11:0] base,
                                                      input logic [11:0] stride);
    return base + bin * stride;
  endfunction

endpackage

// File: rtl/hist_pkt_sink_if.sv
// AXI-Stream style bundle used for both the packet input and the dump output.
interface hist_pkt_sink_if;
  logic [31:0] tdata;
  logic        tvalid;
  logic        tready;
  logic        tlast;

  modport master (output tdata, output tvalid, output tlast, input  tready);
  modport slave  (input  tdata, input  tvalid, input  tlast, output tready);
endinterface

// File: rtl/hist_sink_ram.sv
// Simple dual-port RAM: one write port, one synchronous read port (1-cycle latency).
module hist_sink_ram #(
  parameter int AW = 12,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [2**AW];
  logic [DW-1:0] rdata_q;

  // Read data only moves on re, so it holds while a dump beat is stalled.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata_q <= mem[raddr];
  end

  assign rdata = rdata_q;
endmodule

// File: rtl/hist_pkt_sink.sv
// Histogram packet sink: stores packet values per bin, then dumps bins on request.
// Optional HIST_SINK_CLEAR_ON_DUMP_EN: zero all fill levels after each dump.
module hist_pkt_sink
  import hist_pkg::*;
#(
  parameter int          NUM_BINS   = 8,
  parameter int          BIN_DEPTH  = 32,
  parameter logic [11:0] BASE_ADDR  = DEF_BASE_ADDR,
  parameter logic [11:0] BIN_STRIDE = DEF_BIN_STRIDE
) (
  input  logic             aclk,
  input  logic             aresetn,
  hist_pkt_sink_if.slave   s_axis,
  hist_pkt_sink_if.master  m_axis,
  input  logic             dump_req,
  output logic             busy,
  output logic             err_sticky
);
  localparam int FW = $clog2(BIN_DEPTH) + 1;
  localparam int SW = (BIN_DEPTH > 1) ? $clog2(BIN_DEPTH) : 1;
  localparam int BW = (NUM_BINS > 1) ? $clog2(NUM_BINS) : 1;

  typedef logic [NUM_BINS-1:0][FW-1:0] fill_arr_t;

  state_e        state_q, state_d;
  fill_arr_t     fill_q, fill_d;
  logic [BW-1:0] bin_q, bin_d;
  logic [SW-1:0] slot_q, slot_d;
  logic [11:0]   addr_q, addr_d;
  logic          tvalid_q, tvalid_d, tlast_q, tlast_d;
  logic          tready_q, tready_d, busy_q, busy_d, err_q, err_d;

  pkt_t          pkt;
  logic          hs, hit, pkt_ok, we, re;
  logic [BW-1:0] hbin;
  logic [FW-1:0] cnt_p1;
  logic [11:0]   waddr, raddr;
  logic [BW:0]   nxt;
  logic [7:0]    rdata;
  dump_t         dword;
  logic          unused_tlast;

  // Lowest non-empty bin at or above start; MSB flags "found".
  function automatic logic [BW:0] first_bin(input fill_arr_t f, input int start);
    logic [BW:0] r;
    r = '0;
    for (int b = NUM_BINS - 1; b >= 0; b--)
      if (b >= start && f[b] != '0) r = {1'b1, b[BW-1:0]};
    return r;
  endfunction

  always_comb begin
    pkt  = pkt_t'(s_axis.tdata);
    hs   = s_axis.tvalid && tready_q;
    hit  = 1'b0;
    hbin = '0;
    for (int k = 0; k < NUM_BINS; k++)
      if (pkt.sa == get_storage_address(12'(k), BASE_ADDR, BIN_STRIDE)) begin
        hit  = 1'b1;
        hbin = k[BW-1:0];
      end
    pkt_ok = (pkt.rsvd == 4'd0) && hit && (int'(pkt.cnt) < BIN_DEPTH);
    we     = hs && pkt_ok;
    waddr  = pkt.sa + {4'd0, pkt.cnt};
    cnt_p1 = FW'(pkt.cnt) + FW'(1);
    err_d  = err_q | (hs && !pkt_ok);
    fill_d = fill_q;
    if (we && cnt_p1 > fill_q[hbin]) fill_d[hbin] = cnt_p1;

    state_d  = state_q;
    bin_d    = bin_q;
    slot_d   = slot_q;
    addr_d   = addr_q;
    tvalid_d = tvalid_q;
    tlast_d  = tlast_q;
    re       = 1'b0;
    nxt      = '0;
    raddr    = get_storage_address(12'(bin_q), BASE_ADDR, BIN_STRIDE) + 12'(slot_q);

    case (state_q)
      // Search fill_d so a packet accepted with dump_req is already counted.
      ST_IDLE: if (dump_req) begin
        nxt = first_bin(fill_d, 0);
        if (nxt[BW]) begin
          state_d = ST_DUMP_RD;
          bin_d   = nxt[BW-1:0];
          slot_d  = '0;
        end
      end
      ST_DUMP_RD: begin
        re       = 1'b1;
        addr_d   = raddr;
        tvalid_d = 1'b1;
        tlast_d  = (FW'(slot_q) + FW'(1)) == fill_q[bin_q];
        state_d  = ST_DUMP_OUT;
      end
      ST_DUMP_OUT: if (m_axis.tready) begin
        tvalid_d = 1'b0;
        tlast_d  = 1'b0;
        if (!tlast_q) begin
          slot_d  = slot_q + SW'(1);
          state_d = ST_DUMP_RD;
        end else begin
          nxt = first_bin(fill_q, int'(bin_q) + 1);
          if (nxt[BW]) begin
            bin_d   = nxt[BW-1:0];
            slot_d  = '0;
            state_d = ST_DUMP_RD;
          end else begin
`ifdef HIST_SINK_CLEAR_ON_DUMP_EN
            state_d = ST_CLEAR;
`else
            state_d = ST_IDLE;
`endif
          end
        end
      end
`ifdef HIST_SINK_CLEAR_ON_DUMP_EN
      ST_CLEAR: begin
        fill_d  = '0;
        state_d = ST_IDLE;
      end
`endif
      default: state_d = ST_IDLE;
    endcase

    tready_d = (state_d == ST_IDLE);
    busy_d   = (state_d != ST_IDLE);
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q  <= ST_IDLE;
      fill_q   <= '0;
      bin_q    <= '0;
      slot_q   <= '0;
      addr_q   <= '0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      tready_q <= 1'b1;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      fill_q   <= fill_d;
      bin_q    <= bin_d;
      slot_q   <= slot_d;
      addr_q   <= addr_d;
      tvalid_q <= tvalid_d;
      tlast_q  <= tlast_d;
      tready_q <= tready_d;
      busy_q   <= busy_d;
      err_q    <= err_d;
    end
  end

  hist_sink_ram #(.AW(ADDR_W), .DW(DATA_W)) u_ram (
    .clk   (aclk),
    .we    (we),
    .waddr (waddr),
    .wdata (pkt.val),
    .re    (re),
    .raddr (raddr),
    .rdata (rdata)
  );

  always_comb begin
    dword      = '0;
    dword.bin  = 3'(bin_q);
    dword.addr = addr_q;
    dword.val  = rdata;
  end

  // RAM output is not reset, so the word is masked to zero when idle.
  assign m_axis.tdata  = tvalid_q ? dword : '0;
  assign m_axis.tvalid = tvalid_q;
  assign m_axis.tlast  = tlast_q;
  assign s_axis.tready = tready_q;
  assign busy          = busy_q;
  assign err_sticky    = err_q;
  assign unused_tlast  = s_axis.tlast;
endmodule

// File: tb/tb_hist_pkt_sink.sv
// Randomized scoreboard bench for hist_pkt_sink against a bin/slot reference model.
module tb_hist_pkt_sink;
  logic clk = 1'b0;
  logic aresetn = 1'b0;
  logic dump_req = 1'b0;
  logic busy, err_sticky;

  hist_pkt_sink_if s_if ();
  hist_pkt_sink_if m_if ();

  always #5 clk = ~clk;

  hist_pkt_sink dut (
    .aclk       (clk),
    .aresetn    (aresetn),
    .s_axis     (s_if),
    .m_axis     (m_if),
    .dump_req   (dump_req),
    .busy       (busy),
    .err_sticky (err_sticky)
  );

  typedef struct {
    logic [31:0] data;
    logic        last;
  } beat_t;

  int         n_chk = 0;
  int         n_fail = 0;
  beat_t      exp_q[$];
  logic [7:0] mem_m [4096];
  int         fill_m [8];
  bit         err_m = 1'b0;
  int         rdy_mode = 0;
  int         beats_seen = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mk(int top, int cnt, int sa, int val);
    return {top[3:0], cnt[7:0], sa[11:0], val[7:0]};
  endfunction

  // Reference: bin index derived arithmetically from the storage address.
  task automatic model_apply(logic [31:0] d);
    int cnt, sa, off, b;
    cnt = int'(d[27:20]);
    sa  = int'(d[19:8]);
    off = sa - 32;
    if (d[31:28] == 4'd0 && cnt < 32 && off >= 0 && off % 32 == 0 && off / 32 < 8) begin
      b = off / 32;
      mem_m[(sa + cnt) % 4096] = d[7:0];
      if (cnt + 1 > fill_m[b]) fill_m[b] = cnt + 1;
    end else err_m = 1'b1;
  endtask

  task automatic push_dump();
    int addr;
    for (int b = 0; b < 8; b++)
      for (int s = 0; s < fill_m[b]; s++) begin
        addr = 32 + 32 * b + s;
        exp_q.push_back('{data: {5'b0, 3'(b), 4'b0, 12'(addr), mem_m[addr]},
                          last: (s == fill_m[b] - 1)});
      end
`ifdef HIST_SINK_CLEAR_ON_DUMP_EN
    for (int b = 0; b < 8; b++) fill_m[b] = 0;
`endif
  endtask

  // Output ready pattern: 0 = always, 1 = random, 2 = held low.
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       m_if.tready = 1'b1;
      1:       m_if.tready = ($urandom_range(0, 3) != 0);
      default: m_if.tready = 1'b0;
    endcase
  end

  logic [31:0] prev_data;
  logic        prev_last;
  bit          prev_stall = 1'b0;
  beat_t       mon_b;

  always @(negedge clk) begin
    if (!aresetn) prev_stall <= 1'b0;
    else begin
      if (prev_stall && m_if.tvalid) begin
        check("hold_data", m_if.tdata, prev_data);
        check("hold_last", 32'(m_if.tlast), 32'(prev_last));
      end
      if (m_if.tvalid && m_if.tready) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_beat: got %h with no beat expected", m_if.tdata);
        end else begin
          mon_b = exp_q.pop_front();
          check("beat_data", m_if.tdata, mon_b.data);
          check("beat_last", 32'(m_if.tlast), 32'(mon_b.last));
          beats_seen <= beats_seen + 1;
        end
      end
      prev_stall <= m_if.tvalid && !m_if.tready;
      prev_data  <= m_if.tdata;
      prev_last  <= m_if.tlast;
    end
  end

  task automatic send(logic [31:0] d);
    bit acc;
    s_if.tvalid = 1'b1;
    s_if.tdata  = d;
    acc = s_if.tready;
    @(posedge clk); #1;
    s_if.tvalid = 1'b0;
    check("in_ready", 32'(acc), 32'd1);
    if (acc) model_apply(d);
  endtask

  task automatic do_reset();
    aresetn = 1'b0;
    @(posedge clk); #1;
    aresetn = 1'b1;
    for (int b = 0; b < 8; b++) fill_m[b] = 0;
    err_m = 1'b0;
    exp_q.delete();
  endtask

  task automatic do_dump(bit chk_lat, int stall, bit with_pkt, logic [31:0] d);
    bit acc, nonempty;
    int t;
    if (stall > 0) begin
      rdy_mode = 2;
      @(posedge clk); #1;
    end
    if (with_pkt) begin
      s_if.tvalid = 1'b1;
      s_if.tdata  = d;
    end
    acc = s_if.tready;
    dump_req = 1'b1;
    @(posedge clk); #1;
    dump_req = 1'b0;
    s_if.tvalid = 1'b0;
    if (with_pkt && acc) model_apply(d);
    nonempty = 1'b0;
    for (int b = 0; b < 8; b++) if (fill_m[b] != 0) nonempty = 1'b1;
    push_dump();
    @(negedge clk);
    if (nonempty) begin
      check("busy_after_req", 32'(busy), 32'd1);
      check("in_ready_after_req", 32'(s_if.tready), 32'd0);
      if (chk_lat) begin
        check("lat_rd_valid", 32'(m_if.tvalid), 32'd0);
        @(negedge clk);
        check("lat_out_valid", 32'(m_if.tvalid), 32'd1);
      end
    end
    if (stall > 0) begin
      repeat (stall) @(negedge clk);
      rdy_mode = 0;
    end
    t = 0;
    while (busy && t < 4000) begin
      check("in_ready_busy", 32'(s_if.tready), 32'd0);
      @(negedge clk);
      t++;
    end
    if (busy) begin
      n_chk++;
      n_fail++;
      $display("FAIL dump_timeout: busy still %0d after %0d cycles", busy, t);
    end
    check("in_ready_idle", 32'(s_if.tready), 32'd1);
    check("beats_pending", 32'(exp_q.size()), 32'd0);
    check("err_sticky", 32'(err_sticky), 32'(err_m));
    @(posedge clk); #1;
  endtask

  initial begin
    int b0, t, r, b, cnt, sa, top;
    s_if.tvalid = 1'b0;
    s_if.tdata  = '0;
    s_if.tlast  = 1'b0;
    for (int i = 0; i < 8; i++) fill_m[i] = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 32'(s_if.tready), 32'd1);
    check("rst_valid", 32'(m_if.tvalid), 32'd0);
    check("rst_last", 32'(m_if.tlast), 32'd0);
    check("rst_data", m_if.tdata, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err", 32'(err_sticky), 32'd0);
    @(posedge clk); #1;
    aresetn = 1'b1;

    // Give every slot a known value; reset then clears fill but keeps RAM.
    for (int bi = 0; bi < 8; bi++)
      for (int s = 0; s < 32; s++) send(mk(0, s, 32 + 32 * bi, int'($urandom_range(0, 255))));
    do_reset();

    // Three slots of bin 2, dumped twice.
    send(mk(0, 0, 'h060, 'h41));
    send(mk(0, 1, 'h060, 'h42));
    send(mk(0, 2, 'h060, 'h43));
    do_dump(1'b1, 0, 1'b0, '0);
    do_dump(1'b1, 0, 1'b0, '0);

    // Dropped packets only: error flag, empty dump.
    do_reset();
    send(mk(0, 0, 'h070, 'h55));
    send(mk(0, 32, 'h020, 'h66));
    @(negedge clk);
    check("err_after_drop", 32'(err_sticky), 32'd1);
    @(posedge clk); #1;
    do_dump(1'b0, 0, 1'b0, '0);

    // Packet accepted in the same cycle as dump_req.
    do_dump(1'b1, 0, 1'b1, mk(0, 0, 'h020, 'h11));

    // Back-pressure on the first beat.
    for (int s = 0; s < 4; s++) send(mk(0, s, 'h0C0, 'hA0 + s));
    do_dump(1'b1, 5, 1'b0, '0);

    // Random mix of valid and malformed packets, random output ready.
    rdy_mode = 1;
    for (int round = 0; round < 4; round++) begin
      for (int n = 0; n < 40; n++) begin
        r   = int'($urandom_range(0, 9));
        b   = int'($urandom_range(0, 7));
        cnt = int'($urandom_range(0, 31));
        sa  = 32 + 32 * b;
        top = 0;
        case (r)
          0: top = int'($urandom_range(1, 15));
          1: sa  = int'($urandom_range(0, 4095));
          2: cnt = int'($urandom_range(32, 255));
          3: sa  = 32 + 32 * b + int'($urandom_range(1, 31));
          default: ;
        endcase
        send(mk(top, cnt, sa, int'($urandom_range(0, 255))));
        if ($urandom_range(0, 4) == 0) begin
          @(posedge clk); #1;
        end
      end
      do_dump(1'b0, 0, 1'b0, '0);
    end
    rdy_mode = 0;
    @(posedge clk); #1;

    // Reset while the second beat is on the bus.
    send(mk(0, 0, 'h080, 'h31));
    send(mk(0, 1, 'h080, 'h32));
    send(mk(0, 2, 'h080, 'h33));
    b0 = beats_seen;
    dump_req = 1'b1;
    @(posedge clk); #1;
    dump_req = 1'b0;
    push_dump();
    t = 0;
    while (!(beats_seen >= b0 + 1 && m_if.tvalid) && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) begin
      n_chk++;
      n_fail++;
      $display("FAIL second_beat_timeout: waited %0d cycles", t);
    end
    #1;
    aresetn = 1'b0;
    @(negedge clk);
    check("mid_rst_valid", 32'(m_if.tvalid), 32'd0);
    check("mid_rst_last", 32'(m_if.tlast), 32'd0);
    check("mid_rst_data", m_if.tdata, 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_in_ready", 32'(s_if.tready), 32'd1);
    check("mid_rst_err", 32'(err_sticky), 32'd0);
    @(posedge clk); #1;
    aresetn = 1'b1;
    for (int i = 0; i < 8; i++) fill_m[i] = 0;
    err_m = 1'b0;
    exp_q.delete();
    b0 = beats_seen;
    do_dump(1'b0, 0, 1'b0, '0);
    check("post_rst_beats", 32'(beats_seen), 32'(b0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/hist_pkt_sink.md
# hist_pkt_sink

Receive end of the histogram packet stream. Accepts 32-bit AXI-Stream packets `{4'b0, count[7:0], storage_addr[11:0], value[7:0]}` from the histogram classifier and stores each `value` in an internal 4096x8 RAM at its bin base address plus slot offset. Tracks a fill level per bin. On request, streams the stored contents back out as an AXI-Stream master, bin by bin, with `tlast` closing each bin.

## Interface
- `NUM_BINS`, 8: number of histogram bins.
- `BIN_DEPTH`, 32: slots per bin. Must be a power of two and no larger than `BIN_STRIDE`.
- `BASE_ADDR`, 12'h020: base address of bin 0.
- `BIN_STRIDE`, 12'h020: address distance between consecutive bin bases.
- `aclk`  in  1  the single clock; all logic is on the rising edge.
- `aresetn`  in  1  reset, **synchronous and active-low**.
- `s_axis_tdata`  in  32  input packet.
- `s_axis_tvalid`  in  1  input valid.
- `s_axis_tready`  out  1  input ready.
- `m_axis_tdata`  out  32  dump word `{5'b0, bin[2:0], 4'b0, addr[11:0], value[7:0]}`.
- `m_axis_tvalid`  out  1  dump valid.
- `m_axis_tready`  in  1  dump ready.
- `m_axis_tlast`  out  1  marks the last slot of a bin.
- `dump_req`  in  1  single-cycle pulse that starts a dump.
- `busy`  out  1  high whenever the state is not IDLE.
- `err_sticky`  out  1  set by any dropped packet; cleared only by reset.

## Operation
- **Packet decode:**
  - `cnt = tdata[27:20]`, `sa = tdata[19:8]`, `val = tdata[7:0]`.
  - Bin is `(sa - BASE_ADDR) / BIN_STRIDE`.
- **Packet validity.** A packet is valid only when all of the following hold:
  - `tdata[31:28] == 0`;
  - `sa` equals `BASE_ADDR + k*BIN_STRIDE` for some `k < NUM_BINS`;
  - `cnt < BIN_DEPTH`.
- **Valid packet:**
  - RAM write at address `sa + cnt`, with 12-bit wrap.
  - `fill[bin] <= max(fill[bin], cnt+1)`. `fill` is `$clog2(BIN_DEPTH)+1` bits wide.
- **Invalid packet:** no write, no change to any `fill` entry, `err_sticky <= 1`. The packet is still handshaken.
- **FSM states:**
  - IDLE: accepts packets.
  - DUMP_RD: issues a RAM read.
  - DUMP_OUT: presents the word and waits for `tready`.
  - CLEAR: present only with the macro below.
- **Transitions:**
  - IDLE → DUMP_RD on `dump_req`.
  - DUMP_RD → DUMP_OUT unconditionally.
  - DUMP_OUT → DUMP_RD when the beat is accepted and more slots remain.
  - DUMP_OUT → IDLE, or → CLEAR with the macro, after the final beat.
- **Dump order:**
  - Bin 0 to `NUM_BINS-1`, slots 0 to `fill-1`.
  - Bins with `fill == 0` are skipped entirely and produce no beat.
  - If every bin is empty, the block returns to IDLE without asserting `m_axis_tvalid`.
- `m_axis_tlast` is 1 on slot `fill-1` of each bin.

## Timing
- **Reset values:**
  - `s_axis_tready = 1`, `m_axis_tvalid = 0`, `m_axis_tlast = 0`, `m_axis_tdata = 0`, `busy = 0`, `err_sticky = 0`.
  - All `fill` entries are 0. RAM contents are not cleared.
- **Input side:**
  - One packet per cycle in IDLE; full throughput.
  - The RAM write and `fill` update land on the edge after the handshake.
  - `s_axis_tready` is 0 in every state other than IDLE.
- **Dump request:**
  - `dump_req` is sampled only in IDLE and ignored elsewhere.
  - If `dump_req` coincides with an input handshake, the packet is accepted and written. `s_axis_tready` drops on the next cycle.
  - Because the write lands before the first RAM read, the dump includes that packet.
- **Dump latency:**
  - RAM reads are synchronous with 1-cycle latency.
  - The first `m_axis_tvalid` appears 2 cycles after the `dump_req` edge.
  - With `m_axis_tready` held high, one beat is emitted every 2 cycles.
- **Output stability:** while `tvalid && !tready`, `tdata` and `tlast` hold unchanged.
- **Return to IDLE:** after the final beat (or after CLEAR), `s_axis_tready = 1` on the next cycle.
- **Reset mid-dump:** outputs and `fill` return to reset values on the next edge; any partially sent bin is abandoned.

## Configuration
- `HIST_SINK_CLEAR_ON_DUMP_EN`:
  - **Defined:** after the final beat, the FSM spends 1 cycle in CLEAR, zeroing all `fill` entries, then enters IDLE. `busy` stays high during CLEAR.
  - **Undefined:** `fill` persists across dumps, and a repeated dump returns identical data.

## Structure
- **Shared package `hist_pkg`:**
  - Packet field bit positions.
  - Default `BASE_ADDR` and `BIN_STRIDE`.
  - FSM state enum.
  - The `get_storage_address`-equivalent base-address function, shared with the classifier.
- **Sub-module `hist_sink_ram`:** 4096x8 simple dual-port RAM (1 write port, 1 synchronous read port).

## Test plan
- Write 3 packets to bin 2 (`sa=0x060`, `cnt=0,1,2`, `val=0x41,0x42,0x43`), then `dump_req` → 3 beats with `addr` 0x060/0x061/0x062 and values 0x41/0x42/0x43; `tlast` only on the 3rd beat.
- Send `sa=0x070`, and separately `cnt=32` → no writes, `err_sticky=1`; a dump of an otherwise empty store produces no beats and `busy` returns to 0.
- Hold `m_axis_tready=0` for 5 cycles mid-dump → `tdata` and `tlast` stable; no beat lost or duplicated.
- Assert `dump_req` in the same cycle as a handshake of `sa=0x020`, `cnt=0`, `val=0x11` → the dump includes `0x11`; `s_axis_tready=0` from the next cycle until the dump ends.
- Assert `aresetn=0` during the second beat → all outputs at reset values next cycle; a subsequent dump produces no beats.
- With `HIST_SINK_CLEAR_ON_DUMP_EN` defined, dump twice → the second dump is empty. Without the macro, both dumps are identical.
